dds_dac_spi_driver: RTL
=======================

Name: dds_dac_spi_driver

Overview:
- Downstream stage of the DDS wave selector.
- Samples the 8-bit `Wave_Data` word once per frame and shifts it MSB-first into a TLC5615-style serial DAC as a fixed-length frame (`DAC_CS_N`, `DAC_SCLK`, `DAC_DIN`).
- The DDS sample rate seen by the analogue output is set by the frame period; the selector's output is free-running, so no upstream handshake exists.

Parameters:
- `DATA_W`, 8: width of the incoming sample.
- `PAD_BITS`, 4: zero bits appended after data (LSB side); `FRAME_BITS = DATA_W + PAD_BITS`.
- `HALF_DIV`, 2: `CLK` cycles per `SCLK` half-period; must be ≥1.
- `GAP_CYCLES`, 4: `CLK` cycles `DAC_CS_N` is held high between frames; must be ≥1.

Ports:
- `CLK` input 1: system clock. The whole block is single-clock.
- `Rst` input 1: reset, synchronous and active-high.
- `En` input 1: level enable; while high, frames are launched back-to-back.
- `Wave_Data` input `DATA_W`: sample from the wave selector.
- `DAC_CS_N` output 1: DAC chip select, active low.
- `DAC_SCLK` output 1: serial clock, idle low; the DAC samples `DAC_DIN` on the rising edge.
- `DAC_DIN` output 1: serial data.
- `Busy` output 1: high whenever state is not IDLE.
- `Frame_Done` output 1: one-cycle pulse in the cycle `DAC_CS_N` returns high.

Behaviour:
- **Reset** (`Rst`=1 at a `CLK` edge, including mid-frame): next state is IDLE and all outputs take these values in the same edge: `DAC_CS_N`=1, `DAC_SCLK`=0, `DAC_DIN`=0, `Busy`=0, `Frame_Done`=0. Shift register, bit counter and divider counter are all cleared. The partial frame is aborted; the DAC discards it because `CS_N` rises.
- **All outputs are registered**; no combinational path from input to output.
- **State machine**: IDLE, LEAD, HIGH, LOW, TRAIL, GAP. A divider counter counts 0..`HALF_DIV`-1 in LEAD/HIGH/LOW/TRAIL; a "tick" is the final count. The counter restarts at every state change.
- **IDLE**:
  - If `En`=1: `shreg <= {Wave_Data, PAD_BITS'b0}`, `bit_cnt <= 0`, `DAC_CS_N <= 0`, `DAC_DIN <= Wave_Data[DATA_W-1]`, go to LEAD.
  - Else remain in IDLE.
- **LEAD**: on tick, `DAC_SCLK <= 1`, go to HIGH (data setup = `HALF_DIV` cycles).
- **HIGH**: on tick, `DAC_SCLK <= 1'b0`.
  - If `bit_cnt == FRAME_BITS-1`: go to TRAIL.
  - Else: shift left, `DAC_DIN <= next bit`, `bit_cnt++`, go to LOW.
- **LOW**: on tick, `DAC_SCLK <= 1`, go to HIGH.
- **TRAIL**: on tick, `DAC_CS_N <= 1`, `DAC_DIN <= 0`, `Frame_Done <= 1` for one cycle, go to GAP.
- **GAP**: after `GAP_CYCLES` cycles, go to IDLE.
- **Timing per frame**:
  - `DAC_CS_N` is low for exactly `(2*FRAME_BITS+1)*HALF_DIV` cycles.
  - Exactly `FRAME_BITS` `SCLK` rising edges occur.
  - With `En` held high, frame-start spacing is `1 + (2*FRAME_BITS+1)*HALF_DIV + GAP_CYCLES` cycles. Defaults give 50-cycle `CS` low and a 55-cycle period.
- **Sample latching**: `Wave_Data` is sampled only in the IDLE→LEAD cycle; changes during a frame are ignored.
- **Enable**:
  - `En` falling mid-frame does not abort; the frame and GAP complete, then the block waits in IDLE.
  - `En` rising during GAP takes effect in IDLE.
- **Counter widths**: `bit_cnt` is `$clog2(FRAME_BITS)` bits; divider/gap counter is `$clog2(max(HALF_DIV, GAP_CYCLES))+1` bits. No wrap-around is permitted within a frame.

Decomposition:
- **Package `dds_pkg`**:
  - State enumeration for this FSM.
  - `DATA_W` default (shared with the wave selector and ROM width).
  - `FRAME_BITS` derivation.
- **Sub-module `dds_tick_counter`**: loadable down/up counter producing the tick for a programmable length. It serves both the half-period divider and the GAP timer.

Test Plan:
- **Reset values**: hold `Rst`=1 for 3 cycles with `En`=1 → `DAC_CS_N`=1, `DAC_SCLK`=0, `DAC_DIN`=0, `Busy`=0, `Frame_Done`=0 throughout; first `CS_N` fall is 1 cycle after `Rst` deasserts.
- **Single frame, 0xA5 (defaults)**: `Wave_Data`=0xA5, pulse `En` for 1 cycle → `DIN` at the 12 `SCLK` rising edges = 1,0,1,0,0,1,0,1,0,0,0,0; `CS_N` low for 50 cycles; `Frame_Done` single pulse as `CS_N` rises; `Busy` then falls 4 cycles later.
- **Mid-frame data change**: `Wave_Data` changes 0x3C→0xFF after the 3rd `SCLK` rise → serial word still 0x3C followed by 0000.
- **Back-to-back frames**: `En` held high, samples 0x00, 0xFF → consecutive `CS_N` falling edges exactly 55 cycles apart; data words 000000000000 then 111111110000.
- **Reset mid-frame**: assert `Rst` at the 6th `SCLK` rise → on the next edge `CS_N`=1, `SCLK`=0, `DIN`=0, no `Frame_Done`; a new frame starts cleanly after release.
- **Non-default parameters**: `HALF_DIV`=1, `GAP_CYCLES`=1, `En` deasserted mid-frame → frame completes with `CS_N` low 25 cycles, then the block idles with no further `SCLK` edges.

Source files
------------

// File: rtl/dds_pkg.sv
// Shared definitions for the DDS output path: sample width, serial frame
// geometry and the DAC driver state encoding.
package dds_pkg;

  localparam int DDS_DATA_W = 8;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_LEAD  = 3'd1,
    ST_HIGH  = 3'd2,
    ST_LOW   = 3'd3,
    ST_TRAIL = 3'd4,
    ST_GAP   = 3'd5
  } dds_state_e;

  function automatic int frame_bits(input int data_w, input int pad_bits);
    return data_w + pad_bits;
  endfunction

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/dds_tick_counter.sv
// Restartable up-counter that flags the last cycle of a programmable-length
// interval; used for both the SCLK half-period and the inter-frame gap.
module dds_tick_counter #(
  parameter int CNT_W = 3
) (
  input  logic             CLK,
  input  logic             Rst,
  input  logic             Restart,
  input  logic [CNT_W-1:0] Len,
  output logic             Tick
);

  logic [CNT_W-1:0] cnt_r;
  logic             tick_s;

  // Tick marks the final count of the current interval.
  always_comb begin
    tick_s = (cnt_r == (Len - CNT_W'(1)));
  end

  // Count up, wrapping to zero on tick or when the owner restarts the interval.
  always_ff @(posedge CLK) begin
    if (Rst) begin
      cnt_r <= '0;
    end else if (Restart || tick_s) begin
      cnt_r <= '0;
    end else begin
      cnt_r <= cnt_r + CNT_W'(1);
    end
  end

  assign Tick = tick_s;

endmodule

// File: rtl/dds_dac_spi_driver.sv
// Serialises one wave-selector sample per frame into a TLC5615-style DAC,
// MSB first with zero padding, all outputs registered.
module dds_dac_spi_driver
  import dds_pkg::*;
#(
  parameter int DATA_W     = DDS_DATA_W,
  parameter int PAD_BITS   = 4,
  parameter int HALF_DIV   = 2,
  parameter int GAP_CYCLES = 4
) (
  input  logic              CLK,
  input  logic              Rst,
  input  logic              En,
  input  logic [DATA_W-1:0] Wave_Data,
  output logic              DAC_CS_N,
  output logic              DAC_SCLK,
  output logic              DAC_DIN,
  output logic              Busy,
  output logic              Frame_Done
);

  localparam int FRAME_BITS = frame_bits(DATA_W, PAD_BITS);
  localparam int BIT_W      = (FRAME_BITS > 1) ? $clog2(FRAME_BITS) : 1;
  localparam int CNT_W      = $clog2(max_int(HALF_DIV, GAP_CYCLES)) + 1;

  dds_state_e            state_r;
  logic [FRAME_BITS-1:0] shreg_r;
  logic [BIT_W-1:0]      bit_cnt_r;
  logic                  cs_n_r;
  logic                  sclk_r;
  logic                  din_r;
  logic                  busy_r;
  logic                  done_r;
  logic [CNT_W-1:0]      len_s;
  logic                  restart_s;
  logic                  tick_s;

  // The shared counter times the gap in GAP and a half-period everywhere else;
  // holding it in restart while idle gives LEAD a full-length first interval.
  always_comb begin
    if (state_r == ST_GAP) begin
      len_s = CNT_W'(GAP_CYCLES);
    end else begin
      len_s = CNT_W'(HALF_DIV);
    end
    restart_s = (state_r == ST_IDLE);
  end

  dds_tick_counter #(
    .CNT_W (CNT_W)
  ) u_tick (
    .CLK     (CLK),
    .Rst     (Rst),
    .Restart (restart_s),
    .Len     (len_s),
    .Tick    (tick_s)
  );

  // Frame sequencer with registered serial-port outputs.
  always_ff @(posedge CLK) begin
    if (Rst) begin
      state_r   <= ST_IDLE;
      shreg_r   <= '0;
      bit_cnt_r <= '0;
      cs_n_r    <= 1'b1;
      sclk_r    <= 1'b0;
      din_r     <= 1'b0;
      busy_r    <= 1'b0;
      done_r    <= 1'b0;
    end else begin
      done_r <= 1'b0;
      case (state_r)
        ST_IDLE: begin
          if (En) begin
            shreg_r   <= {Wave_Data, {PAD_BITS{1'b0}}};
            bit_cnt_r <= '0;
            cs_n_r    <= 1'b0;
            din_r     <= Wave_Data[DATA_W-1];
            busy_r    <= 1'b1;
            state_r   <= ST_LEAD;
          end
        end
        ST_LEAD: begin
          if (tick_s) begin
            sclk_r  <= 1'b1;
            state_r <= ST_HIGH;
          end
        end
        ST_HIGH: begin
          if (tick_s) begin
            sclk_r <= 1'b0;
            if (bit_cnt_r == BIT_W'(FRAME_BITS - 1)) begin
              state_r <= ST_TRAIL;
            end else begin
              shreg_r   <= shreg_r << 1;
              din_r     <= shreg_r[FRAME_BITS-2];
              bit_cnt_r <= bit_cnt_r + BIT_W'(1);
              state_r   <= ST_LOW;
            end
          end
        end
        ST_LOW: begin
          if (tick_s) begin
            sclk_r  <= 1'b1;
            state_r <= ST_HIGH;
          end
        end
        ST_TRAIL: begin
          if (tick_s) begin
            cs_n_r  <= 1'b1;
            din_r   <= 1'b0;
            done_r  <= 1'b1;
            state_r <= ST_GAP;
          end
        end
        ST_GAP: begin
          if (tick_s) begin
            busy_r  <= 1'b0;
            state_r <= ST_IDLE;
          end
        end
        default: begin
          state_r <= ST_IDLE;
          cs_n_r  <= 1'b1;
          sclk_r  <= 1'b0;
          din_r   <= 1'b0;
          busy_r  <= 1'b0;
        end
      endcase
    end
  end

  assign DAC_CS_N   = cs_n_r;
  assign DAC_SCLK   = sclk_r;
  assign DAC_DIN    = din_r;
  assign Busy       = busy_r;
  assign Frame_Done = done_r;

endmodule
